pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Parametrised program-counter and fetch-control register for the pipelined CPU's IF stage. It holds the fetch PC, advances it from the next-PC logic or holds it on stall, and redirects it to the exception handler or to EPC on eret. After a redirect it inserts a configurable number of fetch bubbles. It flags instruction-fetch address errors (AdEL) on misaligned or out-of-range PCs.

## Interface
Parameters:
- WIDTH, 32, PC width in bits (≥ 8)
- RESET_ADDR, 32'h0000_3000, PC value after reset
- IMEM_LO, 32'h0000_3000, lowest legal fetch address (inclusive)
- IMEM_HI, 32'h0000_6ffc, highest legal fetch address (inclusive)
- HANDLER_ADDR, 32'h0000_4180, exception entry address
- BUBBLE, 1, invalid fetch cycles after a redirect (0..7)

Ports:
- Clk  in  1  clock; rising edge
- Reset  in  1  asynchronous, active-low reset
- en  in  1  1 = advance PC to npc; 0 = stall (hold)
- npc  in  WIDTH  next sequential/branch PC from NPC logic
- exc_req  in  1  take exception; redirect to HANDLER_ADDR
- eret_req  in  1  return from exception; redirect to epc
- epc  in  WIDTH  return address from CP0
- pc  out  WIDTH  current fetch PC
- valid  out  1  fetch at pc is real (not a bubble)
- AdEL  out  1  fetch address error on a valid fetch
- redirect  out  1  registered; high for the first cycle after any redirect

## Operation
- States: BOOT, RUN, BUBBLE_WAIT. A 3-bit bubble counter runs only in BUBBLE_WAIT.
- Reset (Reset=0, asynchronous): pc=RESET_ADDR, state=BOOT, counter=0, valid=0, redirect=0, AdEL=0.
- BOOT: lasts exactly one cycle after Reset deasserts, then RUN. The PC holds and all request inputs are ignored.
- Edge priority in RUN and BUBBLE_WAIT: exc_req > eret_req > stall/advance.
  - exc_req=1: pc<=HANDLER_ADDR, regardless of en.
  - else eret_req=1: pc<=epc, regardless of en.
  - else in RUN: pc<=npc if en=1, hold if en=0.
  - else in BUBBLE_WAIT: hold pc; en is ignored.
- Any redirect (exc or eret) sets redirect<=1 for one cycle.
  - BUBBLE>0: state<=BUBBLE_WAIT with counter<=BUBBLE.
  - BUBBLE=0: state<=RUN.
- A redirect during BUBBLE_WAIT restarts the counter at BUBBLE.
- BUBBLE_WAIT: counter decrements each cycle; on reaching 1, the next state is RUN.
- valid = (state==RUN). It is combinational from state.
- AdEL = valid & (pc[1:0]!=0 | pc<IMEM_LO | pc>IMEM_HI). Comparisons are unsigned, full WIDTH, and purely combinational from pc.
- A misaligned or out-of-range epc/npc is loaded as-is; AdEL reports it and the PC does not self-correct.
- exc_req and eret_req high together: exc_req wins, and eret is dropped.

## Timing
- Latency: every PC update is visible one cycle after the sampling edge.
- Redirect at edge t: pc=target and redirect=1 during cycle t+1. valid=0 during cycles t+1..t+BUBBLE; valid=1 from t+BUBBLE+1.
- Stall: en=0 at edge t means pc in cycle t+1 equals pc in cycle t, and valid is unchanged.
- Reset asserted mid-bubble or mid-stall forces reset values immediately, with no clock needed.
- No combinational path exists from any input to any output.

## Test plan
- Reset release, en=1, npc=pc+4: cycle 1 after release pc=0x3000, valid=0 (BOOT). Then valid=1, and pc steps 0x3004, 0x3008 on successive edges. AdEL=0 throughout.
- Stall: hold en=0 for 3 cycles with npc=0x3010 → pc stays 0x300c and valid stays 1. Release en → pc=0x3010 on the next cycle.
- exc_req pulse with BUBBLE=1 → next cycle pc=0x4180, redirect=1, valid=0. Following cycle valid=1, redirect=0.
- exc_req and eret_req together with epc=0x3020 → pc=0x4180. Then eret alone → pc=0x3020 after its bubble.
- Address errors:
  - npc=0x3002 → AdEL=1 once valid.
  - npc=0x2ffc → AdEL=1.
  - npc=0x7000 → AdEL=1.
  - npc=0x6ffc → AdEL=0.
  - Bubble cycle at a bad pc → AdEL=0.
- Reset asserted during BUBBLE_WAIT (BUBBLE=3, counter=2) → pc=0x3000, valid=0, and redirect=0 asynchronously. BOOT is re-entered on release.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register with exception/eret redirect, post-redirect bubbles and AdEL detection.
// Latency: 1 cycle per PC update; en=0 stalls (holds PC), all outputs registered or decoded from state/pc only.
module pc_fetch_ctrl #(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR   = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IMEM_LO      = 32'h0000_3000,
    parameter logic [WIDTH-1:0] IMEM_HI      = 32'h0000_6ffc,
    parameter logic [WIDTH-1:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int unsigned     BUBBLE       = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             en,
    input  logic [WIDTH-1:0] npc,
    input  logic             exc_req,
    input  logic             eret_req,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic             valid,
    output logic             AdEL,
    output logic             redirect
);

    typedef enum logic [1:0] {
        BOOT        = 2'd0,
        RUN         = 2'd1,
        BUBBLE_WAIT = 2'd2
    } state_t;

    localparam logic [2:0] BUBBLE_CNT = 3'(BUBBLE);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             redirect_q, redirect_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= BOOT;
            cnt_q      <= 3'd0;
            pc_q       <= RESET_ADDR;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN, BUBBLE_WAIT: begin
                if (exc_req || eret_req) begin
                    // exc_req beats eret_req; a simultaneous eret is dropped
                    pc_d       = exc_req ? HANDLER_ADDR : epc;
                    redirect_d = 1'b1;
                    if (BUBBLE_CNT != 3'd0) begin
                        state_d = BUBBLE_WAIT;
                        cnt_d   = BUBBLE_CNT;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 3'd0;
                    end
                end else if (state_q == RUN) begin
                    if (en) begin
                        pc_d = npc;
                    end
                end else if (cnt_q <= 3'd1) begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = BOOT;
                cnt_d   = 3'd0;
            end
        endcase
    end

    assign pc       = pc_q;
    assign redirect = redirect_q;
    assign valid    = (state_q == RUN);
    assign AdEL     = valid && ((pc_q[1:0] != 2'b00) || (pc_q < IMEM_LO) || (pc_q > IMEM_HI));

endmodule
